// File: rtl/cnn1d_pkg.sv
// cnn1d_pkg: shared constants for the 1-D CNN datapath
package cnn1d_pkg;
  localparam int DATA_WIDTH = 8;
endpackage

// File: rtl/window_gen.sv
// window_gen: sliding-window producer turning a sample stream into WINDOW_SIZE-wide vectors
//   clk, rst_n                                 clock, async active-low reset
//   win_valid_in/win_ready_in/win_data_in/win_last_in      upstream sample handshake
//   win_valid_out/win_ready_out/win_data_out/win_last_out  downstream window handshake
//   win_data_out[0] is the oldest sample, [WINDOW_SIZE-1] the newest
module window_gen
  import cnn1d_pkg::*;
#(
  parameter int WINDOW_SIZE = 3,
  parameter int STRIDE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  win_ready_in,
  input  logic                  win_valid_in,
  input  logic [DATA_WIDTH-1:0] win_data_in,
  input  logic                  win_last_in,
  input  logic                  win_ready_out,
  output logic                  win_valid_out,
  output logic [DATA_WIDTH-1:0] win_data_out [0:WINDOW_SIZE-1],
  output logic                  win_last_out
);
  localparam int CW = $clog2(WINDOW_SIZE + 1);
  localparam int PW = $clog2(STRIDE + 1);
  if (WINDOW_SIZE < 1 || STRIDE < 1 || STRIDE > WINDOW_SIZE)
    $error("window_gen: need WINDOW_SIZE>=1 and 1<=STRIDE<=WINDOW_SIZE");
  logic [CW-1:0] fill_cnt;
  logic [PW-1:0] phase_cnt;
  logic accept, full, emit, done;
  assign win_ready_in = rst_n & (~win_valid_out | win_ready_out);
  assign accept = win_valid_in & win_ready_in;
  assign full = fill_cnt == CW'(WINDOW_SIZE);
  // first full window, or every STRIDE-th sample once the window stays full
  assign emit = accept & ((fill_cnt == CW'(WINDOW_SIZE - 1)) | (full & (phase_cnt == PW'(STRIDE - 1))));
  assign done = win_valid_out & win_ready_out;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_data_out <= '{default: '0};
      fill_cnt <= '0;
      phase_cnt <= '0;
      win_valid_out <= 1'b0;
      win_last_out <= 1'b0;
    end else begin
      if (accept) begin
        for (int k = 0; k < WINDOW_SIZE - 1; k++) win_data_out[k] <= win_data_out[k+1];
        win_data_out[WINDOW_SIZE-1] <= win_data_in;
        // a last sample restarts filling, so stale window contents never reach the output
        fill_cnt <= win_last_in ? '0 : full ? fill_cnt : fill_cnt + 1'b1;
        phase_cnt <= (win_last_in | emit) ? '0 : full ? phase_cnt + 1'b1 : phase_cnt;
      end
      if (emit) begin
        win_valid_out <= 1'b1;
        win_last_out <= win_last_in;
      end else if (done) begin
        win_valid_out <= 1'b0;
        win_last_out <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_window_gen.sv
// tb_window_gen: randomized and directed self-checking bench for window_gen (W=3, S=1 and S=2)
module tb_window_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic v = 1'b0, l = 1'b0, r = 1'b1, sel = 1'b0;
  logic [7:0] d = '0;
  logic ri1, ri2, vo1, vo2, lo1, lo2;
  logic [7:0] do1 [0:2];
  logic [7:0] do2 [0:2];
  logic ri, vo, lo;
  logic [23:0] dout;
  int n_checks = 0, n_fail = 0;
  int stride = 1;
  logic [7:0] hist[$];
  logic [23:0] expw[$];
  logic expl[$];

  always #5 clk = ~clk;

  window_gen #(.WINDOW_SIZE(3), .STRIDE(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .win_ready_in(ri1), .win_valid_in(v & ~sel),
    .win_data_in(d), .win_last_in(l), .win_ready_out(sel ? 1'b1 : r),
    .win_valid_out(vo1), .win_data_out(do1), .win_last_out(lo1));
  window_gen #(.WINDOW_SIZE(3), .STRIDE(2)) u_s2 (
    .clk(clk), .rst_n(rst_n), .win_ready_in(ri2), .win_valid_in(v & sel),
    .win_data_in(d), .win_last_in(l), .win_ready_out(sel ? r : 1'b1),
    .win_valid_out(vo2), .win_data_out(do2), .win_last_out(lo2));

  assign ri = sel ? ri2 : ri1;
  assign vo = sel ? vo2 : vo1;
  assign lo = sel ? lo2 : lo1;
  assign dout = sel ? {do2[0], do2[1], do2[2]} : {do1[0], do1[1], do1[2]};

  task automatic clear_model();
    hist.delete();
    expw.delete();
    expl.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; v = 1'b0; l = 1'b0; r = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
  endtask

  // one clock: drive, score any completed output handshake, update the model on accept
  task automatic step(input logic vv, input logic [7:0] dd, input logic ll, input logic rr);
    int n;
    @(negedge clk);
    v = vv; d = dd; l = ll; r = rr;
    #1;
    if (vo && r) begin
      n_checks++;
      if (expw.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_window got %h last %b, required none", dout, lo);
      end else begin
        if (dout !== expw[0] || lo !== expl[0]) begin
          n_fail++;
          $display("FAIL window got %h last %b, required %h last %b", dout, lo, expw[0], expl[0]);
        end
        void'(expw.pop_front());
        void'(expl.pop_front());
      end
    end
    if (v && ri) begin
      hist.push_back(d);
      n = hist.size();
      if (n >= 3 && (n - 3) % stride == 0) begin
        expw.push_back({hist[n-3], hist[n-2], hist[n-1]});
        expl.push_back(l);
      end
      if (l) hist.delete();
    end
    @(posedge clk);
  endtask

  task automatic drain(input string name);
    repeat (4) step(1'b0, 8'h00, 1'b0, 1'b1);
    v = 1'b0;
    n_checks++;
    if (expw.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing got %0d windows outstanding, required 0", name, expw.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ri1 !== 1'b0 || ri2 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready got %b%b, required 00", ri1, ri2);
    end
    do_reset();
    #1;
    n_checks++;
    if (vo1 !== 1'b0 || lo1 !== 1'b0 || {do1[0], do1[1], do1[2]} !== 24'h0 || vo2 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state got valid %b last %b data %h, required 0 0 000000", vo1, lo1, {do1[0], do1[1], do1[2]});
    end
  endtask

  task automatic test_stride1();
    sel = 1'b0; stride = 1;
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      step(1'b1, 8'(k), 1'b0, 1'b1);
      #1;
      n_checks++;
      if (vo !== (k >= 3)) begin
        n_fail++;
        $display("FAIL s1_valid_after_%0d got %b, required %b", k, vo, k >= 3);
      end
    end
    drain("s1");
  endtask

  task automatic test_stride2();
    sel = 1'b1; stride = 2;
    do_reset();
    for (int k = 1; k <= 7; k++) begin
      step(1'b1, 8'(k), 1'b0, 1'b1);
      #1;
      n_checks++;
      if (vo !== (k == 3 || k == 5 || k == 7)) begin
        n_fail++;
        $display("FAIL s2_valid_after_%0d got %b, required %b", k, vo, k == 3 || k == 5 || k == 7);
      end
    end
    drain("s2");
  endtask

  task automatic test_stall();
    sel = 1'b0; stride = 1;
    do_reset();
    for (int k = 1; k <= 3; k++) step(1'b1, 8'(k), 1'b0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      step(1'b1, 8'd4, 1'b0, 1'b0);
      #1;
      n_checks++;
      if (ri !== 1'b0 || vo !== 1'b1 || dout !== 24'h010203) begin
        n_fail++;
        $display("FAIL stall_hold got ready %b valid %b data %h, required 0 1 010203", ri, vo, dout);
      end
    end
    step(1'b1, 8'd4, 1'b0, 1'b1);
    #1;
    n_checks++;
    if (vo !== 1'b1 || dout !== 24'h020304) begin
      n_fail++;
      $display("FAIL stall_release got valid %b data %h, required 1 020304", vo, dout);
    end
    drain("stall");
  endtask

  task automatic test_last();
    sel = 1'b0; stride = 1;
    do_reset();
    for (int k = 1; k <= 4; k++) step(1'b1, 8'(k), k == 4, 1'b1);
    #1;
    n_checks++;
    if (vo !== 1'b1 || lo !== 1'b1 || dout !== 24'h020304) begin
      n_fail++;
      $display("FAIL last_flag got valid %b last %b data %h, required 1 1 020304", vo, lo, dout);
    end
    for (int k = 10; k <= 12; k++) step(1'b1, 8'(k), 1'b0, 1'b1);
    drain("last");
  endtask

  task automatic test_short();
    sel = 1'b0; stride = 1;
    do_reset();
    step(1'b1, 8'd1, 1'b0, 1'b1);
    step(1'b1, 8'd2, 1'b1, 1'b1);
    step(1'b1, 8'd5, 1'b0, 1'b1);
    #1;
    n_checks++;
    if (vo !== 1'b0) begin
      n_fail++;
      $display("FAIL short_no_output got valid %b, required 0", vo);
    end
    step(1'b1, 8'd6, 1'b0, 1'b1);
    step(1'b1, 8'd7, 1'b0, 1'b1);
    drain("short");
  endtask

  task automatic test_async_reset();
    sel = 1'b0; stride = 1;
    do_reset();
    for (int k = 1; k <= 3; k++) step(1'b1, 8'(k), 1'b0, 1'b1);
    step(1'b1, 8'd9, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (vo !== 1'b0 || lo !== 1'b0 || ri !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset got valid %b last %b ready %b, required 0 0 0", vo, lo, ri);
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    step(1'b1, 8'd20, 1'b0, 1'b1);
    step(1'b1, 8'd21, 1'b0, 1'b1);
    #1;
    n_checks++;
    if (vo !== 1'b0) begin
      n_fail++;
      $display("FAIL async_refill got valid %b after 2 samples, required 0", vo);
    end
    step(1'b1, 8'd22, 1'b0, 1'b1);
    drain("async");
  endtask

  task automatic test_random(input logic s);
    sel = s; stride = s ? 2 : 1;
    do_reset();
    for (int c = 0; c < 400; c++)
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0);
    drain(s ? "rand_s2" : "rand_s1");
  endtask

  initial begin
    test_reset();
    test_stride1();
    test_stride2();
    test_stall();
    test_last();
    test_short();
    test_async_reset();
    test_random(1'b0);
    test_random(1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
